// File: rtl/nibble_logger_pkg.sv
// Shared types and sizing for the nibble change logger.
// NIBBLE_LOGGER_TS_EN selects whether FIFO entries carry a timestamp.
package nibble_logger_pkg;

    typedef enum logic {
        IDLE,
        TRACK
    } state_e;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_TS_W   = 12;
    localparam int unsigned DEF_DEPTH  = 8;

`ifdef NIBBLE_LOGGER_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Stored entry width: value plus timestamp only when timestamps are built.
    function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned ts_w);
        return TS_EN ? (data_w + ts_w) : data_w;
    endfunction

    localparam int unsigned ENTRY_W = entry_w(DEF_DATA_W, DEF_TS_W);

endpackage

// File: rtl/logger_fifo.sv
// Synchronous FIFO for logger entries; storage unreset, pointers/count reset.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module logger_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign rd_en = pop_i && !empty_o;
    // When full, the write slot equals the head slot being popped this cycle.
    assign wr_en = push_i && (!full_o || rd_en);

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/nibble_change_logger.sv
// Records every change of the observed word as a {timestamp, value} FIFO entry.
// NIBBLE_LOGGER_TS_EN builds the timestamp counter; otherwise out_ts is 0.
module nibble_change_logger
    import nibble_logger_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     enable,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned EW = entry_w(DATA_W, TS_W);

    state_e            state_q;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              ovf_q, ovf_d;
    logic              evt, pop, full, empty;
    logic [EW-1:0]     wdata, rdata;

    assign evt = enable && ((state_q == IDLE) || (in_data != prev_q));
    assign pop = !empty && out_ready;

    assign out_valid = !empty;
    assign overflow  = ovf_q;

    always_comb begin
        prev_d = enable ? in_data : prev_q;
        ovf_d  = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        // A dropped event in the same cycle as a clear leaves the flag set.
        if (evt && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
            unique case (state_q)
                IDLE:    if (enable)  state_q <= TRACK;
                TRACK:   if (!enable) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NIBBLE_LOGGER_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d     = enable ? (ts_q + 1'b1) : ts_q;
    assign wdata    = {ts_q, in_data};
    assign out_data = rdata[DATA_W-1:0];
    assign out_ts   = rdata[EW-1 -: TS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`else
    assign wdata    = in_data;
    assign out_data = rdata;
    assign out_ts   = '0;
`endif

    logger_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (evt),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_nibble_change_logger.sv
// Directed self-checking bench for nibble_change_logger.
// Expected timestamps follow NIBBLE_LOGGER_TS_EN (0 when timestamps are not built).
module tb_nibble_change_logger;

`ifdef NIBBLE_LOGGER_TS_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        enable;
    logic        ovf_clr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [11:0] out_ts;
    logic [3:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    nibble_change_logger #(
        .DATA_W (4),
        .TS_W   (12),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .enable    (enable),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ets(input int t);
        return TS_ON ? 12'(t) : 12'h000;
    endfunction

    function automatic logic [3:0] tog(input int i);
        return (i % 2 == 1) ? 4'b1010 : 4'b0101;
    endfunction

    task automatic do_reset();
        enable    = 1'b0;
        ovf_clr   = 1'b0;
        out_ready = 1'b0;
        in_data   = 4'b0000;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
        check("rst_ts", out_ts, 0);

        // Constant input logs exactly one first-sample entry
        enable  = 1'b1;
        in_data = 4'b1010;
        step();
        check("first_count", count, 1);
        check("first_valid", out_valid, 1);
        check("first_data", out_data, 4'b1010);
        check("first_ts", out_ts, ets(0));
        step();
        step();
        check("const_count", count, 1);

        // Change events drained immediately
        do_reset();
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int c = 0; c < 18; c++) begin
            in_data = (c < 5) ? 4'b1010 : (c < 15) ? 4'b1100 : 4'b0000;
            step();
            check($sformatf("chg_valid_c%0d", c), out_valid, (c == 0 || c == 5 || c == 15));
            if (c == 0 || c == 5 || c == 15) begin
                check($sformatf("chg_data_c%0d", c), out_data, in_data);
                check($sformatf("chg_ts_c%0d", c), out_ts, ets(c));
            end
        end

        // Overflow: 10 events into 8 slots
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = tog(i);
            step();
        end
        enable = 1'b0;
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head_data", out_data, tog(0));
        check("ovf_head_ts", out_ts, ets(0));
        step();
        check("ovf_hold_count", count, 8);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // Drop and clear in the same cycle: set wins
        enable  = 1'b1;
        in_data = 4'b1111;
        ovf_clr = 1'b1;
        step();
        enable  = 1'b0;
        ovf_clr = 1'b0;
        check("set_wins", overflow, 1);
        check("set_wins_count", count, 8);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr2", overflow, 0);

        // Full FIFO: event and pop together
        enable    = 1'b1;
        in_data   = 4'b0011;
        out_ready = 1'b1;
        step();
        enable    = 1'b0;
        out_ready = 1'b0;
        check("fullpp_count", count, 8);
        check("fullpp_ovf", overflow, 0);
        check("fullpp_head_data", out_data, tog(1));
        check("fullpp_head_ts", out_ts, ets(1));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_data_%0d", k), out_data, (k < 7) ? tog(k + 1) : 4'b0011);
            check($sformatf("drain_ts_%0d", k), out_ts, (k < 7) ? ets(k + 1) : ets(11));
            step();
        end
        out_ready = 1'b0;
        check("empty_valid", out_valid, 0);
        check("empty_count", count, 0);
        check("empty_data", out_data, 0);
        check("empty_ts", out_ts, 0);

        // Disabled cycles: no entries, timestamp frozen at 12
        for (int i = 1; i <= 4; i++) begin
            in_data = 4'(i);
            step();
            check($sformatf("dis_count_%0d", i), count, 0);
        end
        enable  = 1'b1;
        in_data = 4'b0110;
        step();
        check("reen_count", count, 1);
        check("reen_data", out_data, 4'b0110);
        check("reen_ts", out_ts, ets(12));

        // Asynchronous reset with 3 entries queued
        in_data = 4'b0111;
        step();
        in_data = 4'b1000;
        step();
        check("pre_rst_count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_count", count, 0);
        check("async_data", out_data, 0);
        check("async_ts", out_ts, 0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        enable  = 1'b1;
        in_data = 4'b1001;
        step();
        check("post_rst_count", count, 1);
        check("post_rst_data", out_data, 4'b1001);
        check("post_rst_ts", out_ts, ets(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
